// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory for exe-stage loads and stores.
// Takes one request at a time, applies RISC-V sub-word masking/extension, and answers with a single response pulse.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [2:0]          r_size;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [DEPTH];

    logic                w_xfer;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_bad;
    logic                w_access;
    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         w_old;
    logic [31:0]         w_wword;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ldata;
    logic                w_unused;

    // Byte address bits above the memory span simply wrap.
    assign w_unused = ^req_addr[31:ADDR_W+2];

    assign w_xfer     = req_valid && (r_state == IDLE);
    assign w_illegal  = (req_size == 3'b011) || (req_size == 3'b110) || (req_size == 3'b111) ||
                        (req_size[2] && req_we);
    assign w_misalign = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_size == 3'b010) && (req_addr[1:0] != 2'b00));
    assign w_bad      = w_illegal || w_misalign;

    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[ADDR_W+1:2];
    assign w_old    = r_mem[w_idx];

    always_comb begin
        w_wword = w_old;
        w_byte  = w_old[7:0];
        w_half  = r_addr[1] ? w_old[31:16] : w_old[15:0];
        case (r_addr[1:0])
            2'd0:    w_byte = w_old[7:0];
            2'd1:    w_byte = w_old[15:8];
            2'd2:    w_byte = w_old[23:16];
            default: w_byte = w_old[31:24];
        endcase
        case (r_size[1:0])
            2'b00: begin
                case (r_addr[1:0])
                    2'd0:    w_wword[7:0]   = r_wdata[7:0];
                    2'd1:    w_wword[15:8]  = r_wdata[7:0];
                    2'd2:    w_wword[23:16] = r_wdata[7:0];
                    default: w_wword[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) w_wword[31:16] = r_wdata[15:0];
                else           w_wword[15:0]  = r_wdata[15:0];
            end
            default: w_wword = r_wdata;
        endcase
    end

    always_comb begin
        case (r_size)
            3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ldata = {24'd0, w_byte};
            3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
            3'b101:  w_ldata = {16'd0, w_half};
            default: w_ldata = w_old;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (w_xfer) w_next = w_bad ? RESP : WAIT;
            end
            WAIT: begin
                if (r_cnt == 4'd0) w_next = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                w_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_size     <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr[ADDR_W+1:0];
                        r_wdata <= req_wdata;
                        if (w_bad) begin
                            resp_rdata <= 32'd0;
                            resp_err   <= 1'b1;
                        end else begin
                            r_cnt <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        resp_rdata <= r_we ? 32'd0 : w_ldata;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; a write only happens on the access edge of a legal store.
    always_ff @(posedge clk) begin
        if (w_access && r_we) r_mem[w_idx] <= w_wword;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array reference model.
module tb_dmem_responder;
    localparam int LAT = 2;
    localparam int AW  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] mdl [1024];

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected result straight from the ISA rules: byte width, lane shift, mask, extension.
    task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
        int w, sh, nb;
        logic [31:0] mask, word;
        w  = int'((a >> 2) % 1024);
        sh = 8 * int'(a % 4);
        nb = (sz % 4 == 0) ? 1 : (sz % 4 == 1) ? 2 : 4;
        rd = 32'd0;
        er = 1'b0;
        lat = LAT + 1;
        if (sz == 3 || sz > 5 || (we && sz >= 4)) er = 1'b1;
        else if ((sz % 4 == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) er = 1'b1;
        if (er) begin
            lat = 1;
            return;
        end
        word = mdl[w];
        mask = (nb == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * nb)) - 1) << sh);
        if (we) begin
            mdl[w] = (word & ~mask) | ((wd << sh) & mask);
        end else begin
            rd = (word & mask) >> sh;
            if (sz < 4 && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'h1 << (8 * nb)) - 1);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response pulse.
    task automatic xact(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
        logic [31:0] erd;
        logic        eer;
        int          elat, k;
        logic        stall_ok;
        model(we, sz, a, wd, erd, eer, elat);
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (!(busy && !req_ready)) stall_ok = 1'b0;
        end while (!resp_valid && k < 40);
        chk({tag, " latency"}, k, elat);
        chk({tag, " stall"}, {31'd0, stall_ok}, 32'd1);
        chk({tag, " rdata"}, resp_rdata, erd);
        chk({tag, " err"}, {31'd0, resp_err}, {31'd0, eer});
        @(negedge clk);
        chk({tag, " idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int p1, p2, c, seen;
        logic [31:0] a, d;
        logic [2:0]  sz;
        logic        we;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst err", {31'd0, resp_err}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) xact(1'b1, 3'b010, 32'(i * 4), $urandom, "init sw");

        xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw 10");
        xact(1'b0, 3'b010, 32'h10, 32'd0, "lw 10");
        xact(1'b1, 3'b010, 32'h20, 32'h0, "sw 20");
        xact(1'b1, 3'b000, 32'h23, 32'h80, "sb 23");
        xact(1'b0, 3'b000, 32'h23, 32'd0, "lb 23");
        xact(1'b0, 3'b100, 32'h23, 32'd0, "lbu 23");
        xact(1'b0, 3'b010, 32'h20, 32'd0, "lw 20");
        xact(1'b1, 3'b010, 32'h30, 32'h1234_ABCD, "sw 30");
        xact(1'b1, 3'b001, 32'h32, 32'h8001, "sh 32");
        xact(1'b0, 3'b001, 32'h32, 32'd0, "lh 32");
        xact(1'b0, 3'b101, 32'h32, 32'd0, "lhu 32");
        xact(1'b0, 3'b010, 32'h30, 32'd0, "lw 30");
        xact(1'b0, 3'b010, 32'h11, 32'd0, "lw misaligned");
        xact(1'b1, 3'b010, 32'h40, 32'h5A5A_0F0F, "sw 40");
        xact(1'b1, 3'b001, 32'h41, 32'hFFFF, "sh misaligned");
        xact(1'b0, 3'b010, 32'h40, 32'd0, "lw 40");
        xact(1'b0, 3'b011, 32'h40, 32'd0, "size 011");
        xact(1'b1, 3'b100, 32'h40, 32'd0, "sbu illegal");
        xact(1'b1, 3'b010, 32'h1000, 32'h1234_5678, "sw wrap");
        xact(1'b0, 3'b010, 32'h0, 32'd0, "lw 0");

        // Held request: second accept only after the first pulse has cleared.
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h10;
        p1 = -1; p2 = -1; c = 0;
        while (p2 < 0 && c < 40) begin
            @(negedge clk);
            c++;
            if (resp_valid) begin
                if (p1 < 0) p1 = c;
                else p2 = c;
            end
        end
        req_valid = 1'b0;
        chk("held spacing", p2 - p1, LAT + 2);
        chk("held rdata", resp_rdata, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);

        // Reset while a store is waiting: dropped, nothing written.
        xact(1'b1, 3'b010, 32'h50, 32'h0, "sw 50");
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h50;
        req_wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("pre-rst busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1 chk("mid-rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("dropped resp", seen, 0);
        xact(1'b0, 3'b010, 32'h50, 32'd0, "lw 50 after rst");

        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            d  = $urandom;
            xact(we, sz, a, d, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the execute stage's load/store requests. Replaces the zero-latency combinational data lookup with a handshaked, multi-cycle data memory.
- Accepts one request at a time and applies RISC-V sub-word store masks and load sign/zero extension.
- Returns exactly one response pulse per accepted request, after a configurable number of wait states.
- Its busy/not-ready status is what exe uses to stall.

Parameters:
- ADDR_W, 10, word-address width; the memory holds 2**ADDR_W 32-bit words.
- LATENCY, 2, wait-state cycles between accept and response. Legal range is 1..15; a value outside this range is an elaboration error.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  exe presents a request.
- req_ready  out  1  responder can accept; a transfer happens when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word lives in the low bits.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal size; valid with resp_valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On transfer, latch we/size/addr/wdata and check legality.
  - Illegal: size in {011,110,111}, or size 100 with we=1 (BU is load-only; the same rule applies to HU). Illegal requests go to RESP with err=1; no memory access.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Misaligned requests also go to RESP with err=1; no access.
  - Otherwise: counter=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - While counter>0, decrement it.
  - When counter==0, perform the access and go to RESP.
  - The store write is committed on that edge; load data is registered on that same edge.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - The next state is always IDLE.
  - There is no response backpressure: exe must be able to consume the pulse.
- Latency: request accepted at edge N → resp_valid is high during cycle N+LATENCY+1. An error response is high during cycle N+1. Maximum throughput is one request per LATENCY+2 cycles.
- Addressing:
  - word index = addr[ADDR_W+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 2**(ADDR_W+2).
- Stores (read-modify-write of a single word):
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes half lane addr[1] with wdata[15:0].
  - SW writes the whole word.
- Loads:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend the selected lane.
  - LW returns the full word.
- resp_rdata/resp_err are held at their last value outside the pulse. They are updated only on the cycle they become valid.
- Reset mid-operation:
  - A request in WAIT is dropped and produces no response.
  - A store whose commit edge has not yet occurred is not written.
- req_valid while busy is ignored; it is not queued.

Test Plan:
- Word round trip: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → resp_rdata=0xDEADBEEF, resp_err=0, with each response exactly LATENCY+1 cycles after its accept.
- Byte extension: SW 0x20 ← 0x00000000, then SB 0x23 ← 0x80. LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080; LW 0x20 → 0x80000000.
- Half extension: SH 0x32 ← 0x8001. LH 0x32 → 0xFFFF8001; LHU 0x32 → 0x00008001; the low half of word 0x30 is unchanged.
- Errors:
  - LW 0x11 → resp_err=1, rdata=0, one cycle after accept.
  - SH 0x41 → err, and word 0x40 is unchanged.
  - size 011 → err.
- Handshake/wrap (ADDR_W=10):
  - req_ready=0 and busy=1 from accept until after the pulse.
  - A second req_valid held high is accepted only in the next IDLE.
  - SW 0x1000 ← 0x12345678, then LW 0x0 → 0x12345678.
- Reset mid-WAIT: SW 0x50 ← 0xAAAA5555 (after prior value 0x0), assert rst=0 during WAIT → no resp_valid; after release, LW 0x50 → 0x00000000.
